// File: rtl/lift_door_ctrl.sv
// lift_door_ctrl
// Car door sequencer. After the car stops (arrive) the door is taken
// through OPENING, OPEN (dwell) and CLOSING; the move permit door_closed is
// only granted once the door is fully shut. All timing is counted in slowref
// strobes using a single down-counter with terminal-count compare at zero.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   slowref       in   one-clk timing strobe
//   arrive        in   pulse: car stopped at a floor
//   open_req      in   pulse: door-open call while stationary
//   obstruct      in   level: doorway blocked
//   door_closed   out  move permit, high only in CLOSED
//   door_open_led out  high in every state except CLOSED
//   door_done     out  one-cycle pulse when CLOSING completes
//   door_state    out  0=CLOSED 1=OPENING 2=OPEN 3=CLOSING
//   reopen_cnt    out  reopens since last arrive, saturating at 15
//   proto_err     out  sticky: arrive seen outside CLOSED
//
// state   | meaning
// CLOSED  | door shut, car may move
// OPENING | door travelling open
// OPEN    | door fully open, dwell timer running
// CLOSING | door travelling shut, any obstruct/open_req reopens
module lift_door_ctrl #(
    parameter int OPEN_TICKS  = 4,
    parameter int DWELL_TICKS = 16,
    parameter int CLOSE_TICKS = 4,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slowref,
    input  logic       arrive,
    input  logic       open_req,
    input  logic       obstruct,
    output logic       door_closed,
    output logic       door_open_led,
    output logic       door_done,
    output logic [1:0] door_state,
    output logic [3:0] reopen_cnt,
    output logic       proto_err
);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] OPEN_LD  = CNT_W'(OPEN_TICKS - 1);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_TICKS - 1);
    localparam logic [CNT_W-1:0] CLOSE_LD = CNT_W'(CLOSE_TICKS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_door_done;
    logic [3:0]       r_reopen_cnt;
    logic             r_proto_err;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_done_nxt;
    logic [3:0]       w_reopen_nxt;
    logic             w_err_nxt;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_cnt_dec;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_cnt_dec  = r_cnt - CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_CLOSED;
            r_cnt        <= '0;
            r_door_done  <= 1'b0;
            r_reopen_cnt <= 4'd0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_door_done  <= w_done_nxt;
            r_reopen_cnt <= w_reopen_nxt;
            r_proto_err  <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_done_nxt   = 1'b0;
        w_reopen_nxt = r_reopen_cnt;
        w_err_nxt    = r_proto_err;

        case (r_state)
            ST_CLOSED: begin
                if (arrive || open_req) begin
                    w_state_nxt = ST_OPENING;
                    w_cnt_nxt   = OPEN_LD;
                end
                if (arrive) begin
                    w_reopen_nxt = 4'd0;
                end
            end
            ST_OPENING: begin
                // obstruct and open_req are irrelevant while already opening
                if (slowref) begin
                    if (w_cnt_zero) begin
                        w_state_nxt = ST_OPEN;
                        w_cnt_nxt   = DWELL_LD;
                    end else begin
                        w_cnt_nxt = w_cnt_dec;
                    end
                end
            end
            ST_OPEN: begin
                // open_req reloads on any cycle; obstruct only on a strobe
                if (open_req) begin
                    w_cnt_nxt = DWELL_LD;
                end else if (slowref) begin
                    if (obstruct) begin
                        w_cnt_nxt = DWELL_LD;
                    end else if (w_cnt_zero) begin
                        w_state_nxt = ST_CLOSING;
                        w_cnt_nxt   = CLOSE_LD;
                    end else begin
                        w_cnt_nxt = w_cnt_dec;
                    end
                end
            end
            ST_CLOSING: begin
                // a reopen beats a same-cycle expiry, so no door_done then
                if (obstruct || open_req) begin
                    w_state_nxt = ST_OPENING;
                    w_cnt_nxt   = OPEN_LD;
                    if (r_reopen_cnt != 4'd15) begin
                        w_reopen_nxt = r_reopen_cnt + 4'd1;
                    end
                end else if (slowref) begin
                    if (w_cnt_zero) begin
                        w_state_nxt = ST_CLOSED;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_dec;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_CLOSED;
                w_cnt_nxt   = '0;
            end
        endcase

        if (arrive && (r_state != ST_CLOSED)) begin
            w_err_nxt = 1'b1;
        end
    end

    assign door_state    = r_state;
    assign door_closed   = (r_state == ST_CLOSED);
    assign door_open_led = (r_state != ST_CLOSED);
    assign door_done     = r_door_done;
    assign reopen_cnt    = r_reopen_cnt;
    assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_lift_door_ctrl.sv
// Directed bench for lift_door_ctrl with OPEN=2, DWELL=3, CLOSE=2 and a
// slowref strobe every fourth clock. Inputs change on the falling edge,
// outputs are sampled 1 ns after the rising edge.
module tb_lift_door_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       slowref, arrive, open_req, obstruct;
    logic       door_closed, door_open_led, door_done, proto_err;
    logic [1:0] door_state;
    logic [3:0] reopen_cnt;

    int checks = 0;
    int errors = 0;

    lift_door_ctrl #(
        .OPEN_TICKS (2),
        .DWELL_TICKS(3),
        .CLOSE_TICKS(2),
        .CNT_W      (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .slowref      (slowref),
        .arrive       (arrive),
        .open_req     (open_req),
        .obstruct     (obstruct),
        .door_closed  (door_closed),
        .door_open_led(door_open_led),
        .door_done    (door_done),
        .door_state   (door_state),
        .reopen_cnt   (reopen_cnt),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    // One clock with the given pulse inputs; obstruct keeps its current level.
    task automatic cyc(input logic sr, input logic ar, input logic oq);
        @(negedge clk);
        slowref  = sr;
        arrive   = ar;
        open_req = oq;
        @(posedge clk);
        #1;
        slowref  = 1'b0;
        arrive   = 1'b0;
        open_req = 1'b0;
    endtask

    // n strobe periods: three quiet clocks then the strobe clock.
    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
            cyc(1, 0, 0);
        end
    endtask

    task automatic test_reset;
        checks++; if (door_closed !== 1'b1) begin errors++; $display("FAIL rst_closed got %b exp 1", door_closed); end
        checks++; if (door_open_led !== 1'b0) begin errors++; $display("FAIL rst_led got %b exp 0", door_open_led); end
        checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", door_state); end
        checks++; if (door_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", door_done); end
        checks++; if (reopen_cnt !== 4'd0) begin errors++; $display("FAIL rst_reopen got %0d exp 0", reopen_cnt); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", proto_err); end
    endtask

    task automatic test_plain_cycle;
        logic [1:0] exp_st [7] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        int bad_closed = 0;
        int done_seen  = 0;
        cyc(0, 1, 0);
        checks++; if (door_state !== 2'd1) begin errors++; $display("FAIL plain_arrive_state got %0d exp 1", door_state); end
        checks++; if (door_closed !== 1'b0) begin errors++; $display("FAIL plain_arrive_closed got %b exp 0", door_closed); end
        checks++; if (door_open_led !== 1'b1) begin errors++; $display("FAIL plain_led got %b exp 1", door_open_led); end
        for (int s = 0; s < 7; s++) begin
            for (int c = 0; c < 4; c++) begin
                cyc(c == 3, 0, 0);
                if (door_done) done_seen++;
                if (door_closed && !(s == 6 && c == 3)) bad_closed++;
            end
            checks++; if (door_state !== exp_st[s]) begin errors++; $display("FAIL plain_state strobe %0d got %0d exp %0d", s + 1, door_state, exp_st[s]); end
        end
        checks++; if (door_done !== 1'b1) begin errors++; $display("FAIL plain_done_at_7 got %b exp 1", door_done); end
        checks++; if (door_closed !== 1'b1) begin errors++; $display("FAIL plain_closed_end got %b exp 1", door_closed); end
        checks++; if (bad_closed !== 0) begin errors++; $display("FAIL plain_early_closed got %0d exp 0", bad_closed); end
        cyc(0, 0, 0);
        checks++; if (door_done !== 1'b0) begin errors++; $display("FAIL plain_done_width got %b exp 0", door_done); end
        checks++; if (done_seen !== 1) begin errors++; $display("FAIL plain_done_count got %0d exp 1", done_seen); end
    endtask

    task automatic test_obstruct_open;
        cyc(0, 1, 0);
        strobes(2);
        checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL obs_in_open got %0d exp 2", door_state); end
        obstruct = 1'b1;
        strobes(5);
        checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL obs_held got %0d exp 2", door_state); end
        obstruct = 1'b0;
        strobes(2);
        checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL obs_after2 got %0d exp 2", door_state); end
        strobes(1);
        checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL obs_after3 got %0d exp 3", door_state); end
        strobes(2);
        checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL obs_closed got %0d exp 0", door_state); end
    endtask

    task automatic test_reopen;
        int exp_r;
        cyc(0, 1, 0);
        strobes(5);
        checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL reopen_closing got %0d exp 3", door_state); end
        for (int i = 0; i < 17; i++) begin
            exp_r = (i + 1 > 15) ? 15 : i + 1;
            obstruct = 1'b1;
            cyc(0, 0, 0);
            obstruct = 1'b0;
            checks++; if (door_state !== 2'd1) begin errors++; $display("FAIL reopen_state %0d got %0d exp 1", i, door_state); end
            checks++; if (reopen_cnt !== 4'(exp_r)) begin errors++; $display("FAIL reopen_cnt %0d got %0d exp %0d", i, reopen_cnt, exp_r); end
            checks++; if (door_done !== 1'b0) begin errors++; $display("FAIL reopen_done %0d got %b exp 0", i, door_done); end
            if (i < 16) strobes(5);
        end
        strobes(7);
        checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL reopen_final_state got %0d exp 0", door_state); end
        checks++; if (reopen_cnt !== 4'd15) begin errors++; $display("FAIL reopen_sat got %0d exp 15", reopen_cnt); end
    endtask

    task automatic test_collision;
        cyc(0, 1, 0);
        checks++; if (reopen_cnt !== 4'd0) begin errors++; $display("FAIL coll_arrive_clear got %0d exp 0", reopen_cnt); end
        strobes(6);
        checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL coll_closing got %0d exp 3", door_state); end
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(1, 0, 1);
        checks++; if (door_state !== 2'd1) begin errors++; $display("FAIL coll_close_state got %0d exp 1", door_state); end
        checks++; if (door_done !== 1'b0) begin errors++; $display("FAIL coll_close_done got %b exp 0", door_done); end
        checks++; if (reopen_cnt !== 4'd1) begin errors++; $display("FAIL coll_reopen got %0d exp 1", reopen_cnt); end
        strobes(7);
        checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL coll_reclosed got %0d exp 0", door_state); end
        // arrive and open_req together from CLOSED
        cyc(0, 1, 1);
        checks++; if (door_state !== 2'd1) begin errors++; $display("FAIL coll_dual_state got %0d exp 1", door_state); end
        checks++; if (reopen_cnt !== 4'd0) begin errors++; $display("FAIL coll_dual_reopen got %0d exp 0", reopen_cnt); end
        // open_req on the expiring OPEN strobe reloads dwell
        strobes(4);
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(1, 0, 1);
        checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL coll_open_state got %0d exp 2", door_state); end
        strobes(2);
        checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL coll_open_reload got %0d exp 2", door_state); end
        strobes(1);
        checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL coll_open_expire got %0d exp 3", door_state); end
        strobes(2);
        checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL coll_end got %0d exp 0", door_state); end
    endtask

    task automatic test_proto_err;
        cyc(0, 1, 0);
        strobes(2);
        cyc(0, 1, 0);
        checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL proto_state got %0d exp 2", door_state); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_set got %b exp 1", proto_err); end
        strobes(2);
        checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL proto_cnt_kept got %0d exp 2", door_state); end
        strobes(1);
        checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL proto_closing got %0d exp 3", door_state); end
        strobes(2);
        checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL proto_closed got %0d exp 0", door_state); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b exp 1", proto_err); end
    endtask

    task automatic test_reset_mid;
        int done_seen = 0;
        cyc(0, 1, 0);
        strobes(5);
        obstruct = 1'b1;
        cyc(0, 0, 0);
        obstruct = 1'b0;
        strobes(1);
        checks++; if (reopen_cnt !== 4'd1) begin errors++; $display("FAIL rmid_pre_reopen got %0d exp 1", reopen_cnt); end
        checks++; if (door_state !== 2'd1) begin errors++; $display("FAIL rmid_pre_state got %0d exp 1", door_state); end
        #2 reset = 1'b1;
        #1;
        checks++; if (door_closed !== 1'b1) begin errors++; $display("FAIL rmid_closed got %b exp 1", door_closed); end
        checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL rmid_state got %0d exp 0", door_state); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rmid_err got %b exp 0", proto_err); end
        checks++; if (reopen_cnt !== 4'd0) begin errors++; $display("FAIL rmid_reopen got %0d exp 0", reopen_cnt); end
        #1 reset = 1'b0;
        cyc(0, 1, 0);
        checks++; if (door_state !== 2'd1) begin errors++; $display("FAIL rmid_arrive got %0d exp 1", door_state); end
        for (int s = 0; s < 7; s++) begin
            for (int c = 0; c < 4; c++) begin
                cyc(c == 3, 0, 0);
                if (door_done) done_seen++;
            end
            if (s == 5) begin
                checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL rmid_s6 got %0d exp 3", door_state); end
            end
        end
        checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL rmid_final got %0d exp 0", door_state); end
        checks++; if (door_done !== 1'b1) begin errors++; $display("FAIL rmid_done got %b exp 1", door_done); end
        checks++; if (done_seen !== 1) begin errors++; $display("FAIL rmid_done_count got %0d exp 1", done_seen); end
    endtask

    initial begin
        reset    = 1'b1;
        slowref  = 1'b0;
        arrive   = 1'b0;
        open_req = 1'b0;
        obstruct = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        reset = 1'b0;
        test_plain_cycle;
        test_obstruct_open;
        test_reopen;
        test_collision;
        test_proto_err;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lift_door_ctrl.md
# lift_door_ctrl

Car door sequencer for the three-floor lift. `lift_sm` issues a one-cycle `arrive` pulse when the car stops at a floor. This block then runs the door through opening, dwell, closing and obstruction reopen. It grants `door_closed` (move permit) back to `lift_sm` only once the door is fully shut. All door timing is counted in `slowref` strobes, the design's shared slow reference.

## Interface
- `OPEN_TICKS`, default 4: `slowref` strobes for the door to open fully (≥1).
- `DWELL_TICKS`, default 16: `slowref` strobes the door stays open (≥1).
- `CLOSE_TICKS`, default 4: `slowref` strobes for the door to close fully (≥1).
- `CNT_W`, default 5: tick counter width; must hold max(ticks)-1.

Ports:
- `clk`  in  1  50 MHz system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `slowref`  in  1  one-`clk`-wide timing strobe.
- `arrive`  in  1  one-cycle pulse from `lift_sm`: car stopped at a floor.
- `open_req`  in  1  one-cycle pulse: hall/door-open call at the current floor while stationary.
- `obstruct`  in  1  debounced level: doorway blocked.
- `door_closed`  out  1  move permit; high only in CLOSED.
- `door_open_led`  out  1  high in every state except CLOSED.
- `door_done`  out  1  one-cycle pulse when CLOSING completes.
- `door_state`  out  2  0=CLOSED, 1=OPENING, 2=OPEN, 3=CLOSING.
- `reopen_cnt`  out  4  reopens since last `arrive`; saturates at 15.
- `proto_err`  out  1  sticky: `arrive` received outside CLOSED.

## Operation
- Outputs are registered; a tick counter `cnt` (CNT_W bits) decrements only on `slowref`.
- CLOSED:
  - `arrive` or `open_req` → OPENING, `cnt`=OPEN_TICKS-1.
  - `arrive` also clears `reopen_cnt`.
- OPENING, on `slowref`:
  - `cnt`==0 → OPEN, `cnt`=DWELL_TICKS-1.
  - Otherwise `cnt`-1.
  - `obstruct` and `open_req` have no effect.
- OPEN, checked in priority order:
  1. `open_req` (any cycle) → reload `cnt`=DWELL_TICKS-1.
  2. `obstruct` high on a `slowref` → reload DWELL_TICKS-1.
  3. `slowref` with `cnt`==0 → CLOSING, `cnt`=CLOSE_TICKS-1.
  4. `slowref` otherwise → `cnt`-1.
- CLOSING:
  - `obstruct` or `open_req` on any cycle, regardless of `slowref` → OPENING, `cnt`=OPEN_TICKS-1, `reopen_cnt`+1 (saturating).
  - Otherwise on `slowref`: `cnt`==0 → CLOSED with `door_done`=1 for that one cycle; else `cnt`-1.
- `arrive` in any state other than CLOSED:
  - State and `cnt` are unchanged.
  - Sets `proto_err`, which clears only on `reset`.
- `reset` (any time, including mid-operation) sets:
  - state CLOSED, `cnt`=0;
  - `door_closed`=1, `door_open_led`=0, `door_done`=0;
  - `door_state`=0, `reopen_cnt`=0, `proto_err`=0.

## Timing
- Event-to-state latency is 1 `clk`: an `arrive` sampled at edge N gives `door_state`=1 and `door_closed`=0 after edge N.
- `door_closed`, `door_open_led` and `door_state` change on the same edge as the state register.
- `door_done` is high exactly one `clk` per completed close. It coincides with the first cycle of `door_closed`=1.
- Unobstructed cycle from `arrive` to `door_done` is OPEN_TICKS+DWELL_TICKS+CLOSE_TICKS `slowref` strobes. The transition happens on the edge sampling the final strobe.
- Same-cycle `slowref` expiry plus reopen in CLOSING: reopen wins; no `door_done`.
- Same-cycle `slowref` expiry plus `open_req` in OPEN: reload wins.
- Same-cycle `arrive` and `open_req` in CLOSED: single OPENING entry; `reopen_cnt` cleared.

## Test plan
Bench parameters: OPEN_TICKS=2, DWELL_TICKS=3, CLOSE_TICKS=2; `slowref` every 4 `clk`.
- Plain cycle: `arrive` pulse, then 7 strobes, no `obstruct` → `door_state` sequence 1,2,3,0; `door_done` single pulse on 7th strobe edge; `door_closed`=0 throughout until then.
- Obstruct in OPEN: hold `obstruct` for 5 strobes during OPEN → stays in OPEN (state 2); CLOSING entered 3 strobes after `obstruct` drops.
- Reopen while closing: `obstruct` pulse (1 `clk`, off-strobe) during CLOSING → OPENING next edge, `reopen_cnt`=1, no `door_done`. Repeat 17 times → `reopen_cnt` saturates at 15.
- Collision: `open_req` on the same cycle as the final CLOSING strobe → OPENING, `door_done` stays 0. Next `arrive` (after close) → `reopen_cnt`=0.
- Protocol error: `arrive` during OPEN → state unchanged, `proto_err`=1, which stays 1 through a full cycle.
- Reset mid-OPENING: assert `reset` asynchronously between clock edges → immediately `door_closed`=1, `door_state`=0, `proto_err`=0, `reopen_cnt`=0. After release, a fresh `arrive` completes a full 7-strobe cycle.
